// File: rtl/hazard_if.sv
// Pipeline hazard bus: per-stage register/enable inputs toward the hazard unit
// and its stall, squash, bypass and performance-counter outputs.
interface hazard_if #(
  parameter int CNT_W = 16
);
  logic [4:0]       Rs1_D;
  logic [4:0]       Rs2_D;
  logic [4:0]       Rs1_E;
  logic [4:0]       Rs2_E;
  logic [4:0]       Rd_E;
  logic [4:0]       Rd_M;
  logic [4:0]       Rd_W;
  logic             RegWrite_E;
  logic             RegWrite_M;
  logic             RegWrite_W;
  logic             MemRead_E;
  logic             MemRead_M;
  logic             Redirect_E;
  logic             Stall_F;
  logic             Stall_D;
  logic             Flush_D;
  logic             flush;
  logic             LWflush;
  logic [1:0]       ForwardA_E;
  logic [1:0]       ForwardB_E;
  logic [CNT_W-1:0] StallCycles;
  logic [CNT_W-1:0] RedirectCnt;

  modport master (
    output Rs1_D, Rs2_D, Rs1_E, Rs2_E, Rd_E, Rd_M, Rd_W,
    output RegWrite_E, RegWrite_M, RegWrite_W, MemRead_E, MemRead_M, Redirect_E,
    input  Stall_F, Stall_D, Flush_D, flush, LWflush, ForwardA_E, ForwardB_E,
    input  StallCycles, RedirectCnt
  );

  modport slave (
    input  Rs1_D, Rs2_D, Rs1_E, Rs2_E, Rd_E, Rd_M, Rd_W,
    input  RegWrite_E, RegWrite_M, RegWrite_W, MemRead_E, MemRead_M, Redirect_E,
    output Stall_F, Stall_D, Flush_D, flush, LWflush, ForwardA_E, ForwardB_E,
    output StallCycles, RedirectCnt
  );
endinterface

// File: rtl/hazard_unit.sv
// Pipeline hazard unit: RAW stall sequencing, redirect squash, EX bypass selects and
// saturating perf counters. Define FORWARDING_EN to enable the bypass network.
module hazard_unit #(
  parameter int CNT_W = 16
) (
  input logic     clk,
  input logic     rst_n,
  hazard_if.slave hz
);

  localparam logic [0:0] ST_RUN   = 1'b0;
  localparam logic [0:0] ST_STALL = 1'b1;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [0:0]       state_q, state_d;
  logic [1:0]       count_q, count_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] redir_cnt_q, redir_cnt_d;
  logic [1:0]       need_s;
  logic             stall_s;
  logic             flush_s;
  logic             stall_out_s;
  logic             flush_out_s;
  logic [1:0]       fwd_a_s;
  logic [1:0]       fwd_b_s;
  logic             unused_s;

  function automatic logic rd_hit(input logic [4:0] rd, input logic [4:0] rs1,
                                  input logic [4:0] rs2);
    return (rd != 5'd0) && ((rd == rs1) || (rd == rs2));
  endfunction

`ifdef FORWARDING_EN
  // A loaded value is not yet on the MEM bypass path, so MEM loads fall back to WB.
  function automatic logic [1:0] fwd_sel(input logic [4:0] rs, input logic rw_m,
                                         input logic mr_m, input logic [4:0] rd_m,
                                         input logic rw_w, input logic [4:0] rd_w);
    if (rw_m && !mr_m && (rd_m != 5'd0) && (rd_m == rs)) begin
      return 2'b10;
    end else if (rw_w && (rd_w != 5'd0) && (rd_w == rs)) begin
      return 2'b01;
    end else begin
      return 2'b00;
    end
  endfunction
`endif

  // Stall depth for the instruction in ID and the EX operand bypass selects
  always_comb begin
    need_s  = 2'd0;
    fwd_a_s = 2'b00;
    fwd_b_s = 2'b00;
`ifdef FORWARDING_EN
    if (hz.MemRead_E && rd_hit(hz.Rd_E, hz.Rs1_D, hz.Rs2_D)) begin
      need_s = 2'd1;
    end else begin
      need_s = 2'd0;
    end
    fwd_a_s = fwd_sel(hz.Rs1_E, hz.RegWrite_M, hz.MemRead_M, hz.Rd_M, hz.RegWrite_W, hz.Rd_W);
    fwd_b_s = fwd_sel(hz.Rs2_E, hz.RegWrite_M, hz.MemRead_M, hz.Rd_M, hz.RegWrite_W, hz.Rd_W);
`else
    if (hz.RegWrite_E && rd_hit(hz.Rd_E, hz.Rs1_D, hz.Rs2_D)) begin
      need_s = 2'd2;
    end else if (hz.RegWrite_M && rd_hit(hz.Rd_M, hz.Rs1_D, hz.Rs2_D)) begin
      need_s = 2'd1;
    end else begin
      need_s = 2'd0;
    end
`endif
  end

`ifdef FORWARDING_EN
  assign unused_s = hz.RegWrite_E;
`else
  assign unused_s = ^{hz.Rs1_E, hz.Rs2_E, hz.Rd_W, hz.RegWrite_W, hz.MemRead_E, hz.MemRead_M};
`endif

  // Stall sequencer; a redirect overrides any stall and returns to RUN
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    stall_s = 1'b0;
    flush_s = 1'b0;
    if (hz.Redirect_E) begin
      flush_s = 1'b1;
      state_d = ST_RUN;
      count_d = 2'd0;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (need_s != 2'd0) begin
            stall_s = 1'b1;
            if (need_s > 2'd1) begin
              state_d = ST_STALL;
              count_d = need_s - 2'd1;
            end else begin
              state_d = ST_RUN;
              count_d = 2'd0;
            end
          end else begin
            state_d = ST_RUN;
            count_d = 2'd0;
          end
        end
        ST_STALL: begin
          stall_s = 1'b1;
          if (count_q <= 2'd1) begin
            state_d = ST_RUN;
            count_d = 2'd0;
          end else begin
            state_d = ST_STALL;
            count_d = count_q - 2'd1;
          end
        end
        default: begin
          state_d = ST_RUN;
          count_d = 2'd0;
        end
      endcase
    end
  end

  // Controls stay quiet while reset is held so a pending hazard cannot leak out
  assign stall_out_s = rst_n & stall_s;
  assign flush_out_s = rst_n & flush_s;

  // Saturating activity counters
  always_comb begin
    if (stall_out_s && (stall_cnt_q != CNT_MAX)) begin
      stall_cnt_d = stall_cnt_q + CNT_ONE;
    end else begin
      stall_cnt_d = stall_cnt_q;
    end
    if (flush_out_s && (redir_cnt_q != CNT_MAX)) begin
      redir_cnt_d = redir_cnt_q + CNT_ONE;
    end else begin
      redir_cnt_d = redir_cnt_q;
    end
  end

  // State and counter registers with synchronous reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_RUN;
      count_q     <= 2'd0;
      stall_cnt_q <= {CNT_W{1'b0}};
      redir_cnt_q <= {CNT_W{1'b0}};
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      stall_cnt_q <= stall_cnt_d;
      redir_cnt_q <= redir_cnt_d;
    end
  end

  assign hz.Stall_F     = stall_out_s;
  assign hz.Stall_D     = stall_out_s;
  assign hz.LWflush     = stall_out_s;
  assign hz.Flush_D     = flush_out_s;
  assign hz.flush       = flush_out_s;
  assign hz.ForwardA_E  = fwd_a_s;
  assign hz.ForwardB_E  = fwd_b_s;
  assign hz.StallCycles = stall_cnt_q;
  assign hz.RedirectCnt = redir_cnt_q;

endmodule
